// File: rtl/ssds_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are bit0=a .. bit6=g, with 1 meaning lit, before any pin polarity is applied.
package ssds_pkg;

  typedef enum logic {
    SCAN_BLANK,
    SCAN_SHOW
  } scan_state_e;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ssds_scan_driver_if.sv
// Connection between the bus-interface stage (master) and the scan driver (slave).
// The slave side carries the board-pin outputs back out.
interface ssds_scan_driver_if;
  import ssds_pkg::*;

  logic                  en;
  logic [SEG_W-1:0]      digit_0;
  logic [SEG_W-1:0]      digit_1;
  logic [SEG_W-1:0]      digit_2;
  logic [SEG_W-1:0]      digit_3;
  logic [NUM_DIGITS-1:0] dots;
  logic [SEG_W-1:0]      seg_out;
  logic                  dp_out;
  logic [NUM_DIGITS-1:0] digit_sel;

  modport master (
    output en, digit_0, digit_1, digit_2, digit_3, dots,
    input  seg_out, dp_out, digit_sel
  );

  modport slave (
    input  en, digit_0, digit_1, digit_2, digit_3, dots,
    output seg_out, dp_out, digit_sel
  );

endinterface

// File: rtl/ssds_scan_prescaler.sv
// Slot counter for the scan driver: counts 0..DIV-1, restarts at 0 on the first enabled cycle,
// and reports (for the upcoming cycle) whether a slot begins and whether it lies in the blank window.
module ssds_scan_prescaler #(
  parameter int DIV          = 50_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic slot_start_o,
  output logic slot_wrap_o,
  output logic in_blank_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // run_q low means the previous cycle was disabled or in reset, so this edge opens slot 0.
  logic             run_q, run_d;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d        = '0;
    run_d        = en_i;
    slot_start_o = 1'b0;
    slot_wrap_o  = 1'b0;
    if (en_i) begin
      if (!run_q) begin
        slot_start_o = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        slot_start_o = 1'b1;
        slot_wrap_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    in_blank_o = (cnt_d < CNT_BLANK);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ssds_scan_driver.sv
// Time-multiplexes four seven-segment digits onto one shared segment/dot bus with one-hot selects,
// blanking all selects at the start of every slot so segment changes never ghost onto a lit digit.
module ssds_scan_driver
  import ssds_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int SCAN_RATE_HZ   = 1000,
  parameter int BLANK_CYCLES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               rst,
  ssds_scan_driver_if.slave bus
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_RATE_HZ;

  if (DIV < 2 || BLANK_CYCLES >= DIV) begin : g_bad_params
    $error("ssds_scan_driver: slot length must be >= 2 and longer than BLANK_CYCLES");
  end

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_INV}};
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_INV}};

  logic slot_start, slot_wrap, blank_next;

  ssds_scan_prescaler #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .en_i         (bus.en),
    .slot_start_o (slot_start),
    .slot_wrap_o  (slot_wrap),
    .in_blank_o   (blank_next)
  );

  logic [1:0]            idx_q, idx_d;
  scan_state_e           state_q, state_d;
  logic [SEG_W-1:0]      snap_seg_q, snap_seg_d;
  logic                  snap_dp_q, snap_dp_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]      digit_mux;

  always_comb begin
    idx_d = idx_q;
    if (!bus.en) begin
      idx_d = '0;
    end else if (slot_wrap) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_comb begin
    digit_mux = bus.digit_0;
    case (idx_d)
      2'd0: digit_mux = bus.digit_0;
      2'd1: digit_mux = bus.digit_1;
      2'd2: digit_mux = bus.digit_2;
      2'd3: digit_mux = bus.digit_3;
      default: digit_mux = bus.digit_0;
    endcase
  end

  // The snapshot is loaded only at slot start, so mid-slot input changes cannot tear the display.
  always_comb begin
    snap_seg_d = snap_seg_q;
    snap_dp_d  = snap_dp_q;
    if (slot_start) begin
      snap_seg_d = digit_mux;
      snap_dp_d  = bus.dots[idx_d];
    end
  end

  always_comb begin
    state_d = SCAN_BLANK;
    if (bus.en && !blank_next) begin
      state_d = SCAN_SHOW;
    end
  end

  // Outputs are computed from next-state values so the pins line up with cnt/idx after each edge.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    sel_d = SEL_OFF;
    if (state_d == SCAN_SHOW) begin
      seg_d = snap_seg_d ^ {SEG_W{SEG_INV}};
      dp_d  = snap_dp_d ^ SEG_INV;
      sel_d = digit_onehot(idx_d) ^ {NUM_DIGITS{SEL_INV}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      state_q <= SCAN_BLANK;
    end else begin
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // NOTE: the snapshot is reset too, so the first slot after reset can never show stale X data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_seg_q <= '0;
      snap_dp_q  <= 1'b0;
    end else begin
      snap_seg_q <= snap_seg_d;
      snap_dp_q  <= snap_dp_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      sel_q <= SEL_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      sel_q <= sel_d;
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.dp_out    = dp_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_ssds_scan_driver.sv
// Directed bench for ssds_scan_driver: expected pin values are queued per cycle as stimulus is
// applied and popped one per clock; random phase checks the select/segment invariants.
`timescale 1ns/1ps
module tb_ssds_scan_driver;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  logic       have_prev;
  logic [3:0] prev_sel;
  logic [6:0] prev_seg;
  logic       prev_dp;

  ssds_scan_driver_if bus ();

  ssds_scan_driver #(
    .CLK_FREQ_HZ    (1000),
    .SCAN_RATE_HZ   (100),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inv();
    checks++;
    assert ($countones(~bus.digit_sel) <= 1) else begin
      errors++;
      $error("FAIL onehot_sel: observed %h expected at most one active at %0t", bus.digit_sel, $time);
    end
    if (have_prev && (bus.seg_out !== prev_seg || bus.dp_out !== prev_dp)) begin
      checks++;
      assert (bus.digit_sel === 4'hF || prev_sel === 4'hF) else begin
        errors++;
        $error("FAIL seg_change_while_selected: observed sel %h->%h expected one of them F at %0t",
               prev_sel, bus.digit_sel, $time);
      end
    end
    have_prev = 1'b1;
    prev_sel  = bus.digit_sel;
    prev_seg  = bus.seg_out;
    prev_dp   = bus.dp_out;
  endtask

  task automatic check_blank(input string tag);
    check_val({tag, "_sel"}, {3'b000, bus.digit_sel}, 7'h0F);
    check_val({tag, "_seg"}, bus.seg_out, 7'h7F);
    check_val({tag, "_dp"}, {6'b0, bus.dp_out}, 7'h01);
    check_inv();
  endtask

  task automatic push_blank(input int n);
    exp_t e;
    e.sel = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_show(input int idx, input logic [6:0] pat, input logic dot, input int n);
    exp_t       e;
    logic [3:0] one;
    one   = 4'b0001 << idx;
    e.sel = ~one;
    e.seg = ~pat;
    e.dp  = ~dot;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_slot(input int idx, input logic [6:0] pat, input logic dot);
    push_blank(2);
    push_show(idx, pat, dot, 8);
  endtask

  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty: observed no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check_val("sel", {3'b000, bus.digit_sel}, {3'b000, e.sel});
        check_val("seg", bus.seg_out, e.seg);
        check_val("dp", {6'b0, bus.dp_out}, {6'b0, e.dp});
      end
      check_inv();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    have_prev   = 1'b0;
    rst         = 1'b0;
    bus.en      = 1'b1;
    bus.digit_0 = 7'h3F;
    bus.digit_1 = 7'h00;
    bus.digit_2 = 7'h00;
    bus.digit_3 = 7'h00;
    bus.dots    = 4'b0000;

    #12;
    check_blank("reset_hold");
    @(negedge clk);
    check_blank("reset_hold_edge");
    rst = 1'b1;

    // first slot after release: 2 blank cycles, then digit 0
    push_slot(0, 7'h3F, 1'b0);
    tick(10);

    // full 40-cycle rotation; digit 0 picks up its new value only on its next slot
    bus.digit_0 = 7'h06;
    bus.digit_1 = 7'h5B;
    bus.digit_2 = 7'h4F;
    bus.digit_3 = 7'h66;
    bus.dots    = 4'b0101;
    push_slot(1, 7'h5B, 1'b0);
    push_slot(2, 7'h4F, 1'b1);
    push_slot(3, 7'h66, 1'b0);
    push_slot(0, 7'h06, 1'b1);
    tick(40);

    // digit_1 changes at cnt=5 of its own slot: no tearing
    push_slot(1, 7'h5B, 1'b0);
    tick(6);
    bus.digit_1 = 7'h7F;
    tick(4);
    push_slot(2, 7'h4F, 1'b1);
    push_slot(3, 7'h66, 1'b0);
    push_slot(0, 7'h06, 1'b1);
    push_slot(1, 7'h7F, 1'b0);
    tick(40);

    // en dropped at cnt=6 of digit 2, held low, then re-raised
    push_blank(2);
    push_show(2, 7'h4F, 1'b1, 5);
    tick(7);
    bus.en = 1'b0;
    push_blank(4);
    tick(4);
    bus.en = 1'b1;
    push_slot(0, 7'h06, 1'b1);
    push_slot(1, 7'h7F, 1'b0);
    tick(20);

    // random digits, dots and enable over 200 slots; invariants only
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(7))
        0: bus.digit_0 = 7'($urandom());
        1: bus.digit_1 = 7'($urandom());
        2: bus.digit_2 = 7'($urandom());
        3: bus.digit_3 = 7'($urandom());
        4: bus.dots    = 4'($urandom());
        default: ;
      endcase
      if ($urandom_range(63) == 0) bus.en = ~bus.en;
      @(posedge clk);
      @(negedge clk);
      check_inv();
    end

    // resync, then assert reset at cnt=7 of digit 0's SHOW window
    bus.en      = 1'b0;
    bus.digit_0 = 7'h5B;
    bus.digit_1 = 7'h06;
    bus.dots    = 4'b0011;
    push_blank(2);
    tick(2);
    bus.en = 1'b1;
    push_blank(2);
    push_show(0, 7'h5B, 1'b1, 6);
    tick(8);
    #2;
    rst = 1'b0;
    #1;
    check_blank("async_reset");
    @(negedge clk);
    check_blank("reset_held");
    rst = 1'b1;
    push_slot(0, 7'h5B, 1'b1);
    push_slot(1, 7'h06, 1'b1);
    tick(20);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssds_scan_driver.md
Name: ssds_scan_driver

Overview:
- Downstream stage of the seven-segment bus interface. Consumes its per-digit segment patterns, dot bits and enable.
- Time-multiplexes the four digits onto one shared segment/dot bus with one-hot digit selects, as physical multiplexed SSD boards require.
- Inserts a blanking interval between digits to suppress ghosting.
- All outputs go to board pins.

Parameters:
- CLK_FREQ_HZ, 50_000_000, input clock frequency.
- SCAN_RATE_HZ, 1000, slot rate. One digit is shown per slot; full refresh = SCAN_RATE_HZ/4.
- BLANK_CYCLES, 64, cycles at the start of each slot with all digits deselected. Must be < DIV.
- SEG_ACTIVE_LOW, 1, seg_out/dp_out polarity (1 = lit when 0).
- SEL_ACTIVE_LOW, 1, digit_sel polarity (1 = selected when 0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  display enable (from bus interface ctrl_en).
- digit_0..digit_3  in  7 each  segment patterns, bit0=a .. bit6=g, 1 = lit.
- dots  in  4  dots[i] lights the DP of digit i, 1 = lit.
- seg_out  out  7  shared segment lines, polarity per SEG_ACTIVE_LOW.
- dp_out  out  1  shared decimal point line, polarity per SEG_ACTIVE_LOW.
- digit_sel  out  4  one-hot digit select, polarity per SEL_ACTIVE_LOW.

Behaviour:
- Slot length and counter
  - DIV = CLK_FREQ_HZ/SCAN_RATE_HZ (integer division).
  - Elaboration error if DIV < 2 or BLANK_CYCLES >= DIV.
  - Slot counter cnt counts 0..DIV-1, then wraps to 0.
  - Digit index idx (2 bits) increments on each wrap: 3 -> 0.
- Snapshot
  - When cnt wraps to 0, digit_{idx_next} and dots[idx_next] are latched into a snapshot register.
  - Input changes mid-slot are not visible until that digit's next slot. No tearing.
- States: BLANK, SHOW.
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while BLANK_CYCLES <= cnt <= DIV-1.
- Outputs are registered and update in the same edge as cnt/idx, so they always correspond to the current register values.
  - BLANK: digit_sel all inactive; seg_out/dp_out all inactive (unlit).
  - SHOW: digit_sel[idx] active, others inactive; seg_out = snapshot segments; dp_out = snapshot dot. All with polarity applied.
- Invariant: at most one digit_sel bit active in any cycle. Segment lines change only while all selects are inactive.
- en low
  - Next edge: cnt=0, idx=0, state BLANK, all outputs inactive.
  - Held there while en stays low.
- en rising
  - First enabled cycle begins slot 0 for digit 0.
  - Snapshot of digit_0/dots[0] taken at that edge.
  - digit_0 becomes visible BLANK_CYCLES+1 cycles after en is sampled high.
- en dropping mid-SHOW: outputs go inactive on the next edge; no partial slot completion.
- Reset (asserted, asynchronous)
  - cnt=0, idx=0, snapshot=0, state BLANK.
  - digit_sel all inactive; seg_out/dp_out inactive, i.e. SEG_ACTIVE_LOW=1 gives seg_out=7'h7F, dp_out=1, digit_sel=4'hF.
- Reset mid-slot: immediate return to reset values. After release, behaves as an en rising edge if en is high.
- cnt width: $clog2(DIV). No other arithmetic.

Decomposition:
- Package ssds_pkg holds:
  - scan state enum {SCAN_BLANK, SCAN_SHOW};
  - NUM_DIGITS = 4;
  - segment bit-index constants SEG_A..SEG_G.
- One natural sub-module: ssds_scan_prescaler (cnt/wrap generation, sync clear on !en), emitting slot_start and in_blank.
- Digit select/snapshot/output logic stays in ssds_scan_driver.

Test Plan (CLK_FREQ_HZ=1000, SCAN_RATE_HZ=100 -> DIV=10; BLANK_CYCLES=2; both polarities active-low):
- Reset with en=1, digit_0=7'h3F: during reset seg_out=7'h7F, dp_out=1, digit_sel=4'hF. After release, cycles 0-1 blank, cycles 2-9 digit_sel=4'hE, seg_out=7'h40.
- Digits 7'h06/7'h5B/7'h4F/7'h66, dots=4'b0101: slots cycle digit_sel E,D,B,7,E with seg_out 79,24,30,19 and dp_out 0,1,0,1. The period is 40 cycles.
- Change digit_1 from 7'h5B to 7'h7F at cnt=5 of digit_1's slot: seg_out stays 7'h24 to slot end. 7'h00 appears on the next digit_1 slot.
- Drop en at cnt=6 of digit_2: next edge digit_sel=4'hF, seg_out=7'h7F, held. Re-raise en: digit_0 shown 3 cycles later.
- Across 200 slots, random digits/dots/en: assert popcount(~digit_sel)<=1 every cycle. Assert seg_out changes only when digit_sel==4'hF.
- Assert rst at cnt=7 during SHOW: outputs inactive in the same cycle (asynchronous). After release, the slot sequence restarts at digit 0.
